seq_det_prog: RTL and testbench

//  Runtime-programmable serial pattern detector, successor to the fixed 6-bit codeword FSM.

---
 rtl/seq_det_pkg.sv | 18 +
 rtl/seq_det_sat_cnt.sv | 29 ++
 rtl/seq_det_prog.sv | 144 ++++++++++++++
 tb/tb_seq_det_prog.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package seq_det_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_HUNT = 2'd2
  } state_e;

  // Builds a mask with the low 'len' bits set, saturating at 32 bits.
  function automatic logic [31:0] len_to_mask(input logic [5:0] len);
    if (len >= 6'd32) return '1;
    else              return (32'd1 << len) - 32'd1;
  endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module seq_det_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear first, otherwise increment until all ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                    cnt_d = '0;
    else if (inc_i && cnt_q != '1) cnt_d = cnt_q + W'(1);
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_det_prog.sv
// Runtime-programmable serial pattern detector with valid-qualified input,
// registered detect pulse and saturating match counter.
// Optional build macro SEQ_DET_PROG_MASK_EN adds a per-position don't-care
// mask (cfg_mask), latched together with the pattern on cfg_load.
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int MAX_W = 6,
  parameter int CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_load,
  input  logic [MAX_W-1:0]             cfg_pattern,
  input  logic [$clog2(MAX_W+1)-1:0]   cfg_len,
  input  logic                         cfg_overlap,
`ifdef SEQ_DET_PROG_MASK_EN
  input  logic [MAX_W-1:0]             cfg_mask,
`endif
  input  logic                         serial_in,
  input  logic                         serial_valid,
  input  logic                         cnt_clr,
  output logic                         armed,
  output logic                         detect,
  output logic [CNT_W-1:0]             match_cnt
);

  localparam int LEN_W = $clog2(MAX_W+1);

  state_e             state_q, state_d;
  logic [MAX_W-2:0]   hist_q, hist_d;     // last MAX_W-1 bits, newest in LSB
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [MAX_W-1:0]   pat_q, pat_d;
  logic               ovl_q, ovl_d;
  logic               detect_q, detect_d;
`ifdef SEQ_DET_PROG_MASK_EN
  logic [MAX_W-1:0]   mask_q, mask_d;
`endif

  logic [MAX_W-1:0]   hist_nx;
  logic [LEN_W-1:0]   fill_nx;
  logic [LEN_W-1:0]   len_clamped;
  logic [31:0]        cmp_mask;
  logic               hit;

  // Out-of-range lengths fall back to the full pattern width.
  assign len_clamped = (cfg_len < LEN_W'(2) || cfg_len > LEN_W'(MAX_W)) ?
                       LEN_W'(MAX_W) : cfg_len;

  // Candidate history/fill as they would be after accepting serial_in.
  assign hist_nx = {hist_q, serial_in};
  assign fill_nx = (fill_q == len_q) ? fill_q : fill_q + LEN_W'(1);

`ifdef SEQ_DET_PROG_MASK_EN
  assign cmp_mask = len_to_mask(6'(len_q)) & 32'(mask_q);
`else
  assign cmp_mask = len_to_mask(6'(len_q));
`endif

  // Pattern completes only once len bits have been collected.
  assign hit = (fill_nx == len_q) && ((32'(hist_nx ^ pat_q) & cmp_mask) == '0);

  // Next-state: load dominates, then valid bits advance history and FSM.
  always_comb begin
    state_d  = state_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    len_d    = len_q;
    pat_d    = pat_q;
    ovl_d    = ovl_q;
    detect_d = 1'b0;
`ifdef SEQ_DET_PROG_MASK_EN
    mask_d   = mask_q;
`endif
    if (cfg_load) begin
      pat_d   = cfg_pattern;
      len_d   = len_clamped;
      ovl_d   = cfg_overlap;
`ifdef SEQ_DET_PROG_MASK_EN
      mask_d  = cfg_mask;
`endif
      hist_d  = '0;
      fill_d  = '0;
      state_d = S_FILL;
    end else if (serial_valid && state_q != S_IDLE) begin
      hist_d = hist_nx[MAX_W-2:0];
      fill_d = fill_nx;
      if (hit) begin
        detect_d = 1'b1;
        if (ovl_q) begin
          state_d = S_HUNT;
        end else begin
          // Non-overlapping: next match needs len fresh bits.
          hist_d  = '0;
          fill_d  = '0;
          state_d = S_FILL;
        end
      end else if (fill_nx == len_q) begin
        state_d = S_HUNT;
      end
    end
  end

  // State, configuration and history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      hist_q   <= '0;
      fill_q   <= '0;
      len_q    <= '0;
      pat_q    <= '0;
      ovl_q    <= 1'b0;
      detect_q <= 1'b0;
`ifdef SEQ_DET_PROG_MASK_EN
      mask_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      len_q    <= len_d;
      pat_q    <= pat_d;
      ovl_q    <= ovl_d;
      detect_q <= detect_d;
`ifdef SEQ_DET_PROG_MASK_EN
      mask_q   <= mask_d;
`endif
    end
  end

  // Counter steps on the same edge that raises detect.
  seq_det_sat_cnt #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .inc_i (detect_d),
    .cnt_o (match_cnt)
  );

  assign armed  = (state_q != S_IDLE);
  assign detect = detect_q;

endmodule

// File: tb/tb_seq_det_prog.sv
// Directed self-checking bench for seq_det_prog (MAX_W=6, CNT_W=2).
module tb_seq_det_prog;

  localparam int MAX_W = 6;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_load;
  logic [MAX_W-1:0] cfg_pattern;
  logic [2:0]       cfg_len;
  logic             cfg_overlap;
`ifdef SEQ_DET_PROG_MASK_EN
  logic [MAX_W-1:0] cfg_mask;
`endif
  logic             serial_in;
  logic             serial_valid;
  logic             cnt_clr;
  logic             armed;
  logic             detect;
  logic [CNT_W-1:0] match_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_det_prog #(.MAX_W(MAX_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_load     (cfg_load),
    .cfg_pattern  (cfg_pattern),
    .cfg_len      (cfg_len),
    .cfg_overlap  (cfg_overlap),
`ifdef SEQ_DET_PROG_MASK_EN
    .cfg_mask     (cfg_mask),
`endif
    .serial_in    (serial_in),
    .serial_valid (serial_valid),
    .cnt_clr      (cnt_clr),
    .armed        (armed),
    .detect       (detect),
    .match_cnt    (match_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [5:0] pat, input logic [2:0] len, input logic ovl);
    cfg_load = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
    serial_valid = 1'b0;
    tick();
    cfg_load = 1'b0;
  endtask

  // Apply one valid bit and check the registered detect that follows it.
  task automatic feed(input logic b, input logic exp_det, input string tag);
    serial_in = b; serial_valid = 1'b1;
    tick();
    serial_valid = 1'b0;
    chk(tag, 32'(detect), 32'(exp_det));
  endtask

  task automatic idle(input logic b);
    serial_in = b; serial_valid = 1'b0;
    tick();
  endtask

  task automatic clear_cnt();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    serial_in = 1'b0; serial_valid = 1'b0; cnt_clr = 1'b0;
`ifdef SEQ_DET_PROG_MASK_EN
    cfg_mask = 6'b111111;
`endif
    tick(); tick();
    chk("rst_armed", 32'(armed), 32'd0);
    chk("rst_detect", 32'(detect), 32'd0);
    chk("rst_cnt", 32'(match_cnt), 32'd0);
    rst_n = 1'b1;
    // Bits without a loaded pattern do nothing.
    feed(1'b0, 1'b0, "idle_nodet");
    chk("idle_armed", 32'(armed), 32'd0);

    // 1: 010110, len 6, no overlap
    load(6'b010110, 3'd6, 1'b0);
    chk("t1_armed", 32'(armed), 32'd1);
    feed(1'b0, 1'b0, "t1_b1"); feed(1'b1, 1'b0, "t1_b2"); feed(1'b0, 1'b0, "t1_b3");
    feed(1'b1, 1'b0, "t1_b4"); feed(1'b1, 1'b0, "t1_b5");
    feed(1'b0, 1'b1, "t1_b6_det");
    chk("t1_cnt", 32'(match_cnt), 32'd1);
    idle(1'b0);
    chk("t1_pulse_1cyc", 32'(detect), 32'd0);
    clear_cnt();
    chk("t1_cnt_clr", 32'(match_cnt), 32'd0);

    // 2a: 1010, len 4, overlap -> detects after bits 4 and 6
    load(6'b001010, 3'd4, 1'b1);
    feed(1'b1, 1'b0, "t2a_b1"); feed(1'b0, 1'b0, "t2a_b2"); feed(1'b1, 1'b0, "t2a_b3");
    feed(1'b0, 1'b1, "t2a_b4"); feed(1'b1, 1'b0, "t2a_b5"); feed(1'b0, 1'b1, "t2a_b6");
    feed(1'b1, 1'b0, "t2a_b7");
    chk("t2a_cnt", 32'(match_cnt), 32'd2);
    clear_cnt();

    // 2b: same stream, no overlap -> detect after bit 4 only
    load(6'b001010, 3'd4, 1'b0);
    feed(1'b1, 1'b0, "t2b_b1"); feed(1'b0, 1'b0, "t2b_b2"); feed(1'b1, 1'b0, "t2b_b3");
    feed(1'b0, 1'b1, "t2b_b4"); feed(1'b1, 1'b0, "t2b_b5"); feed(1'b0, 1'b0, "t2b_b6");
    feed(1'b1, 1'b0, "t2b_b7");
    chk("t2b_cnt", 32'(match_cnt), 32'd1);
    clear_cnt();

    // 3: valid gaps, serial_in wiggling while invalid
    load(6'b010110, 3'd6, 1'b0);
    feed(1'b0, 1'b0, "t3_b1"); idle(1'b1); idle(1'b1);
    feed(1'b1, 1'b0, "t3_b2"); idle(1'b0);
    feed(1'b0, 1'b0, "t3_b3"); idle(1'b1); idle(1'b0);
    feed(1'b1, 1'b0, "t3_b4"); idle(1'b0);
    feed(1'b1, 1'b0, "t3_b5"); idle(1'b1); idle(1'b1);
    feed(1'b0, 1'b1, "t3_b6_det");
    idle(1'b1);
    chk("t3_gap_nodet", 32'(detect), 32'd0);
    chk("t3_cnt", 32'(match_cnt), 32'd1);

    // 4: reset mid-pattern
    load(6'b010110, 3'd6, 1'b0);
    feed(1'b0, 1'b0, "t4_b1"); feed(1'b1, 1'b0, "t4_b2");
    feed(1'b0, 1'b0, "t4_b3"); feed(1'b1, 1'b0, "t4_b4");
    #2 rst_n = 1'b0;
    #1;
    chk("t4_async_armed", 32'(armed), 32'd0);
    chk("t4_async_cnt", 32'(match_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    feed(1'b1, 1'b0, "t4_b5"); feed(1'b0, 1'b0, "t4_b6_nodet");
    chk("t4_armed", 32'(armed), 32'd0);
    chk("t4_cnt", 32'(match_cnt), 32'd0);

    // 5: saturation at 3, then clear concurrent with a detect
    load(6'b001010, 3'd4, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      feed(i[0] ? 1'b1 : 1'b0, (i >= 4 && !i[0]) ? 1'b1 : 1'b0, "t5_stream");
    end
    chk("t5_sat", 32'(match_cnt), 32'd3);
    feed(1'b1, 1'b0, "t5_b13");
    cnt_clr = 1'b1;
    feed(1'b0, 1'b1, "t5_b14_det");
    cnt_clr = 1'b0;
    chk("t5_clr_wins", 32'(match_cnt), 32'd0);

    // 6: load coincident with last bit drops it and restarts
    load(6'b010110, 3'd6, 1'b0);
    feed(1'b0, 1'b0, "t6_b1"); feed(1'b1, 1'b0, "t6_b2"); feed(1'b0, 1'b0, "t6_b3");
    feed(1'b1, 1'b0, "t6_b4"); feed(1'b1, 1'b0, "t6_b5");
    cfg_load = 1'b1; serial_in = 1'b0; serial_valid = 1'b1;
    tick();
    cfg_load = 1'b0; serial_valid = 1'b0;
    chk("t6_load_wins", 32'(detect), 32'd0);
    chk("t6_cnt", 32'(match_cnt), 32'd0);
    feed(1'b0, 1'b0, "t6_r1"); feed(1'b1, 1'b0, "t6_r2"); feed(1'b0, 1'b0, "t6_r3");
    feed(1'b1, 1'b0, "t6_r4"); feed(1'b1, 1'b0, "t6_r5"); feed(1'b0, 1'b1, "t6_r6_det");
    clear_cnt();

    // Out-of-range length clamps to 6: a 4-bit match must not fire
    load(6'b010110, 3'd7, 1'b0);
    feed(1'b0, 1'b0, "clamp_b1"); feed(1'b1, 1'b0, "clamp_b2"); feed(1'b1, 1'b0, "clamp_b3");
    feed(1'b0, 1'b0, "clamp_b4"); feed(1'b0, 1'b0, "clamp_b5"); feed(1'b1, 1'b0, "clamp_b6");
    load(6'b010110, 3'd1, 1'b0);
    feed(1'b0, 1'b0, "clamp1_b1"); feed(1'b1, 1'b0, "clamp1_b2"); feed(1'b0, 1'b0, "clamp1_b3");
    feed(1'b1, 1'b0, "clamp1_b4"); feed(1'b1, 1'b0, "clamp1_b5"); feed(1'b0, 1'b1, "clamp1_b6");

`ifdef SEQ_DET_PROG_MASK_EN
    cfg_mask = 6'b111101;
    load(6'b010110, 3'd6, 1'b0);
    feed(1'b0, 1'b0, "mask_b1"); feed(1'b1, 1'b0, "mask_b2"); feed(1'b0, 1'b0, "mask_b3");
    feed(1'b1, 1'b0, "mask_b4"); feed(1'b0, 1'b0, "mask_b5"); feed(1'b0, 1'b1, "mask_b6_det");
    cfg_mask = 6'b111111;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
